// File: rtl/imem_loader.sv
// imem_loader
//   Receives a program over a byte stream and writes it into instruction
//   memory while holding the CPU in reset. The stream is a 32-bit word count N
//   followed by N data words, all little-endian. When the optional checksum is
//   enabled, one more word follows: the modulo-2^32 sum of the data words.
//
// Configuration macro: IMEM_LOADER_CHECKSUM_EN (adds CHK state + accumulator)
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   start       one-cycle request to begin a load (ignored while busy)
//   byte_valid  byte stream valid
//   byte_data   byte stream data
//   byte_ready  byte accepted this cycle (HDR/LOAD/CHK only)
//   we/wa/wd    instruction memory write port (word-aligned byte address)
//   cpu_hold    keeps the core in reset; low only in RUN
//   busy/done/err  load in progress / completed / failed
//
// state | meaning
// IDLE  | after reset, waiting for start
// HDR   | assembling the length word N
// LOAD  | assembling data words and writing them to memory
// CHK   | assembling the checksum word (checksum build only)
// RUN   | load complete, core released
// ERR   | bad length or checksum mismatch, core held

module imem_loader #(
  parameter int DEPTH = 256,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          we,
  output logic [AW-1:0] wa,
  output logic [31:0]   wd,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          err
);

  // Wide enough to hold DEPTH itself, so a length of exactly DEPTH fits.
  localparam int IW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
    RUN,
    ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , CHK
`endif
  } state_t;

  state_t        state;
  logic [1:0]    bcnt;
  logic [23:0]   sh;
  logic [IW-1:0] idx;
  logic [IW-1:0] len;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]   acc;
`endif

  logic        xfer;
  logic        word_done;
  logic [31:0] word;
  logic        last_word;

  always_comb begin
    byte_ready = (state == HDR) || (state == LOAD);
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (state == CHK) byte_ready = 1'b1;
`endif
  end

  assign busy     = byte_ready;
  assign done     = (state == RUN);
  assign err      = (state == ERR);
  assign cpu_hold = (state != RUN);

  assign xfer      = byte_valid && byte_ready;
  assign word_done = xfer && (bcnt == 2'd3);
  // The fourth byte is combined directly, so a word completes in the cycle
  // its last byte transfers and the write is registered on that edge.
  assign word      = {byte_data, sh};
  assign last_word = (idx == len - IW'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      bcnt  <= 2'd0;
      sh    <= 24'd0;
      idx   <= '0;
      len   <= '0;
      we    <= 1'b0;
      wa    <= '0;
      wd    <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      acc   <= 32'd0;
`endif
    end else begin
      we <= 1'b0;

      if (xfer) begin
        bcnt <= bcnt + 2'd1;
        case (bcnt)
          2'd0:    sh[7:0]   <= byte_data;
          2'd1:    sh[15:8]  <= byte_data;
          2'd2:    sh[23:16] <= byte_data;
          default: ;
        endcase
      end

      case (state)
        IDLE, RUN, ERR: begin
          if (start) begin
            state <= HDR;
            bcnt  <= 2'd0;
            idx   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            acc   <= 32'd0;
`endif
          end
        end

        HDR: begin
          if (word_done) begin
            if (word == 32'd0 || word > 32'(DEPTH)) begin
              state <= ERR;
            end else begin
              len   <= word[IW-1:0];
              idx   <= '0;
              state <= LOAD;
            end
          end
        end

        LOAD: begin
          if (word_done) begin
            we  <= 1'b1;
            wa  <= AW'({idx, 2'b00});
            wd  <= word;
`ifdef IMEM_LOADER_CHECKSUM_EN
            acc <= acc + word;
`endif
            // idx stops at len-1, so it can never wrap past DEPTH-1.
            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state <= CHK;
`else
              state <= RUN;
`endif
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (word_done) begin
            state <= (word == acc) ? RUN : ERR;
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader. Inputs are driven on falling edges and
// outputs are sampled on falling edges; a monitor records every write pulse.

module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        we;
  logic [31:0] wa;
  logic [31:0] wd;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(256), .AW(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .we         (we),
    .wa         (wa),
    .wd         (wd),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always @(negedge clk) begin
    if (we === 1'b1) begin
      wa_q.push_back(wa);
      wd_q.push_back(wd);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input int i, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] oa;
    logic [31:0] od;
    oa = (i < wa_q.size()) ? wa_q[i] : 32'hxxxx_xxxx;
    od = (i < wd_q.size()) ? wd_q[i] : 32'hxxxx_xxxx;
    chk({tag, "_wa"}, oa, a);
    chk({tag, "_wd"}, od, d);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_q();
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    tick(1);
    byte_valid = 1'b0;
  endtask

  // gap=1 drops byte_valid for one cycle after every byte.
  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 0; i < 4; i++) begin
      byte_valid = 1'b1;
      byte_data  = w[8*i +: 8];
      tick(1);
      if (gap) begin
        byte_valid = 1'b0;
        tick(1);
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic send_sum(input logic [31:0] s, input bit gap);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(s, gap);
`endif
  endtask

  initial begin
    logic [31:0] sum;

    // Reset state
    tick(2);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_wa", wa, 32'd0);
    chk("rst_wd", wd, 32'd0);
    chk("rst_ready", 32'(byte_ready), 32'd0);
    reset = 1'b1;
    tick(2);
    chk("post_rst_we", 32'(we), 32'd0);
    chk("post_rst_q", wa_q.size(), 32'd0);

    // Basic two-word load
    pulse_start();
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_ready", 32'(byte_ready), 32'd1);
    chk("t1_hold", 32'(cpu_hold), 32'd1);
    send_word(32'h0000_0002, 0);
    send_word(32'hE3A0_0001, 0);
    send_word(32'hE3A0_1002, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("t1_chk_busy", 32'(busy), 32'd1);
    chk("t1_chk_hold", 32'(cpu_hold), 32'd1);
`endif
    send_sum(32'hC740_1003, 0);
    tick(2);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_hold_rel", 32'(cpu_hold), 32'd0);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_nwr", wa_q.size(), 32'd2);
    chk_wr("t1_w0", 0, 32'h0, 32'hE3A0_0001);
    chk_wr("t1_w1", 1, 32'h4, 32'hE3A0_1002);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Bad checksum
    clear_q();
    pulse_start();
    send_word(32'h0000_0002, 0);
    send_word(32'hE3A0_0001, 0);
    send_word(32'hE3A0_1002, 0);
    send_word(32'h0000_0000, 0);
    tick(2);
    chk("cs_err", 32'(err), 32'd1);
    chk("cs_hold", 32'(cpu_hold), 32'd1);
    chk("cs_done", 32'(done), 32'd0);
`endif

    // Oversize length
    clear_q();
    pulse_start();
    send_word(32'h0000_0101, 0);
    tick(2);
    chk("big_err", 32'(err), 32'd1);
    chk("big_hold", 32'(cpu_hold), 32'd1);
    chk("big_busy", 32'(busy), 32'd0);
    chk("big_nwr", wa_q.size(), 32'd0);

    // Zero length
    pulse_start();
    send_word(32'h0000_0000, 0);
    tick(2);
    chk("zero_err", 32'(err), 32'd1);
    chk("zero_nwr", wa_q.size(), 32'd0);

    // Recovery, with a partial word held across a long idle gap
    clear_q();
    pulse_start();
    send_word(32'h0000_0002, 0);
    send_byte(8'h01);
    send_byte(8'h00);
    tick(20);
    chk("hold_busy", 32'(busy), 32'd1);
    chk("hold_nwr", wa_q.size(), 32'd0);
    send_byte(8'hA0);
    send_byte(8'hE3);
    send_word(32'hE3A0_1002, 0);
    send_sum(32'hC740_1003, 0);
    chk("rec_ready_off", 32'(byte_ready), 32'd0);
    chk("rec_done", 32'(done), 32'd1);
    tick(2);
    chk("rec_nwr", wa_q.size(), 32'd2);
    chk_wr("rec_w0", 0, 32'h0, 32'hE3A0_0001);
    chk_wr("rec_w1", 1, 32'h4, 32'hE3A0_1002);

    // byte_valid toggling every cycle
    clear_q();
    pulse_start();
    send_word(32'h0000_0002, 0);
    send_word(32'hE3A0_0001, 1);
    send_word(32'hE3A0_1002, 1);
    send_sum(32'hC740_1003, 1);
    tick(2);
    chk("tog_done", 32'(done), 32'd1);
    chk("tog_nwr", wa_q.size(), 32'd2);
    chk_wr("tog_w0", 0, 32'h0, 32'hE3A0_0001);
    chk_wr("tog_w1", 1, 32'h4, 32'hE3A0_1002);

    // Reset after 6 payload bytes
    clear_q();
    pulse_start();
    send_word(32'h0000_0002, 0);
    send_word(32'hE3A0_0001, 0);
    send_byte(8'h02);
    send_byte(8'h10);
    reset = 1'b0;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_hold", 32'(cpu_hold), 32'd1);
    chk("mrst_ready", 32'(byte_ready), 32'd0);
    chk("mrst_we", 32'(we), 32'd0);
    tick(3);
    reset = 1'b1;
    tick(3);
    chk("mrst_nwr", wa_q.size(), 32'd1);
    chk("mrst_done", 32'(done), 32'd0);
    clear_q();
    pulse_start();
    send_word(32'h0000_0002, 0);
    send_word(32'hE3A0_0001, 0);
    send_word(32'hE3A0_1002, 0);
    send_sum(32'hC740_1003, 0);
    tick(2);
    chk("fresh_done", 32'(done), 32'd1);
    chk("fresh_nwr", wa_q.size(), 32'd2);
    chk_wr("fresh_w1", 1, 32'h4, 32'hE3A0_1002);

    // start pulsed during LOAD
    clear_q();
    pulse_start();
    send_word(32'h0000_0002, 0);
    send_word(32'hE3A0_0001, 0);
    pulse_start();
    chk("st_busy", 32'(busy), 32'd1);
    send_word(32'hE3A0_1002, 0);
    send_sum(32'hC740_1003, 0);
    tick(2);
    chk("st_done", 32'(done), 32'd1);
    chk("st_nwr", wa_q.size(), 32'd2);
    chk_wr("st_w0", 0, 32'h0, 32'hE3A0_0001);
    chk_wr("st_w1", 1, 32'h4, 32'hE3A0_1002);

    // Full-depth load (N = DEPTH)
    clear_q();
    sum = 32'd0;
    pulse_start();
    send_word(32'd256, 0);
    for (int i = 0; i < 256; i++) begin
      send_word(32'hA500_0000 + 32'(i), 0);
      sum = sum + 32'hA500_0000 + 32'(i);
    end
    send_sum(sum, 0);
    tick(2);
    chk("full_done", 32'(done), 32'd1);
    chk("full_nwr", wa_q.size(), 32'd256);
    chk_wr("full_w0", 0, 32'h0, 32'hA500_0000);
    chk_wr("full_wlast", 255, 32'h3FC, 32'hA500_00FF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
